// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-port arbiter with a long-latency result FIFO
// and a pending-write busy mask. The pipeline writeback always owns the port
// when it writes a nonzero register. Buffered long-latency results drain into
// the remaining free slots in acceptance order.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pipe_wen,
    input  logic [4:0]             pipe_rd,
    input  logic [31:0]            pipe_data,
    input  logic                   lu_issue,
    input  logic [4:0]             lu_issue_rd,
    input  logic                   lu_valid,
    input  logic [4:0]             lu_rd,
    input  logic [31:0]            lu_data,
    output logic                   lu_ready,
    output logic [4:0]             rsW,
    output logic [31:0]            dataW_reg,
    output logic                   RegWEn,
    output logic [31:0]            busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     busy_q, busy_d;

    logic   full, empty, pipe_own, accept, pop, wt, push;
    entry_t head;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign pipe_own = pipe_wen && (pipe_rd != 5'd0);
    // Readiness depends only on registered occupancy, never on a same-cycle pop,
    // and is held low for as long as reset is asserted.
    assign lu_ready = !rst && !full;
    assign accept   = lu_valid && lu_ready;
    assign head     = mem_q[rd_ptr_q];
    // A zero-destination result is accepted and dropped without using an entry.
    assign push     = accept && (lu_rd != 5'd0) && !wt;

    assign busy       = busy_q;
    assign fifo_count = count_q;

    // Port selection: pipeline, then FIFO head, then direct write-through.
    always_comb begin
        // NOTE: every signal gets a default before the priority chain so no path
        // leaves it unassigned; an unassigned path would infer a latch.
        rsW       = pipe_rd;
        dataW_reg = pipe_data;
        RegWEn    = 1'b0;
        pop       = 1'b0;
        wt        = 1'b0;
        if (pipe_own) begin
            RegWEn = 1'b1;
        end else if (!empty) begin
            rsW       = head.rd;
            dataW_reg = head.data;
            RegWEn    = 1'b1;
            pop       = 1'b1;
        end else if (accept && (lu_rd != 5'd0)) begin
            rsW       = lu_rd;
            dataW_reg = lu_data;
            RegWEn    = 1'b1;
            wt        = 1'b1;
        end
    end

    // Next-state for pointers, occupancy and the busy mask (set beats clear).
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        busy_d   = busy_q;
        if (pop || wt) begin
            busy_d[rsW] = 1'b0;
        end
        if (lu_issue && (lu_issue_rd != 5'd0)) begin
            busy_d[lu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control state registers; reset discards all pending writes at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage written on push.
    // NOTE: the array is not reset; entries are only read while count_q says
    // they are valid, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{rd: lu_rd, data: lu_data};
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed test of wb_arbiter with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  rsW;
    logic [31:0] dataW_reg;
    logic        RegWEn;
    logic [31:0] busy;
    logic [2:0]  fifo_count;

    int tests = 0;
    int fails = 0;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_wen   (pipe_wen),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .lu_issue   (lu_issue),
        .lu_issue_rd(lu_issue_rd),
        .lu_valid   (lu_valid),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .lu_ready   (lu_ready),
        .rsW        (rsW),
        .dataW_reg  (dataW_reg),
        .RegWEn     (RegWEn),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pipe_wen    = 1'b0;
        pipe_rd     = 5'd0;
        pipe_data   = 32'h0;
        lu_issue    = 1'b0;
        lu_issue_rd = 5'd0;
        lu_valid    = 1'b0;
        lu_rd       = 5'd0;
        lu_data     = 32'h0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
        check({tag, "_wen"}, 32'(RegWEn), 32'd1);
        check({tag, "_rd"}, 32'(rsW), 32'(rd));
        check({tag, "_data"}, dataW_reg, data);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        // Reset state
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", busy, 32'h0);
        check("rst_ready", 32'(lu_ready), 32'd0);
        check("rst_wen", 32'(RegWEn), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(lu_ready), 32'd1);

        // 1: issue rd 5, then write-through of its result
        tick();
        lu_issue = 1'b1; lu_issue_rd = 5'd5;
        tick();
        idle();
        #1;
        check("t1_busy_set", busy, 32'h0000_0020);
        tick();
        check("t1_busy_hold", busy, 32'h0000_0020);
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEAD_BEEF;
        #1;
        check_write("t1_wt", 5'd5, 32'hDEAD_BEEF);
        check("t1_busy_still", busy, 32'h0000_0020);
        tick();
        idle();
        #1;
        check("t1_busy_clr", busy, 32'h0);
        check("t1_count", 32'(fifo_count), 32'd0);
        check("t1_idle_wen", 32'(RegWEn), 32'd0);

        // 2: three results queue behind continuous pipeline writes
        for (int i = 0; i < 4; i++) begin
            pipe_wen = 1'b1; pipe_rd = 5'(i + 1); pipe_data = 32'hA000 + 32'(i);
            lu_valid = (i < 3); lu_rd = 5'(10 + i); lu_data = 32'h1000 + 32'(i);
            #1;
            check_write("t2_pipe", 5'(i + 1), 32'hA000 + 32'(i));
            tick();
        end
        idle();
        #1;
        check("t2_count3", 32'(fifo_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("t2_cnt", 32'(fifo_count), 32'(3 - i));
            check_write("t2_drain", 5'(10 + i), 32'h1000 + 32'(i));
            tick();
        end
        check("t2_count0", 32'(fifo_count), 32'd0);

        // 3: fill to full, hold the 5th, then wrap the pointers
        for (int k = 0; k < 4; k++) begin
            pipe_wen = 1'b1; pipe_rd = 5'd1; pipe_data = 32'hB000;
            lu_valid = 1'b1; lu_rd = 5'(16 + k); lu_data = 32'h2000 + 32'(k);
            #1;
            check("t3_fill_ready", 32'(lu_ready), 32'd1);
            tick();
        end
        lu_rd = 5'd20; lu_data = 32'h2004;
        #1;
        check("t3_full_count", 32'(fifo_count), 32'd4);
        check("t3_full_ready", 32'(lu_ready), 32'd0);
        tick();
        check("t3_held_count", 32'(fifo_count), 32'd4);
        pipe_wen = 1'b0;
        #1;
        check_write("t3_pop1", 5'd16, 32'h2000);
        check("t3_pop_ready", 32'(lu_ready), 32'd0);
        tick();
        pipe_wen = 1'b1;
        #1;
        check("t3_count3", 32'(fifo_count), 32'd3);
        check("t3_ready_back", 32'(lu_ready), 32'd1);
        tick();
        lu_valid = 1'b0; pipe_wen = 1'b0;
        #1;
        check("t3_count4", 32'(fifo_count), 32'd4);
        check_write("t3_pop2", 5'd17, 32'h2001);
        tick();
        for (int j = 0; j < 10; j++) begin
            lu_valid = 1'b1; lu_rd = 5'(21 + j); lu_data = 32'h2005 + 32'(j);
            #1;
            check("t3_wrap_ready", 32'(lu_ready), 32'd1);
            check_write("t3_wrap", 5'(18 + j), 32'h2002 + 32'(j));
            tick();
        end
        idle();
        #1;
        check("t3_wrap_count", 32'(fifo_count), 32'd3);
        for (int j = 0; j < 3; j++) begin
            check_write("t3_tail", 5'(28 + j), 32'h200C + 32'(j));
            tick();
        end
        check("t3_empty", 32'(fifo_count), 32'd0);

        // 4: rd 0 results and pipe writes to rd 0
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h1234;
        lu_issue = 1'b1; lu_issue_rd = 5'd0;
        #1;
        check("t4_lu0_wen", 32'(RegWEn), 32'd0);
        check("t4_lu0_ready", 32'(lu_ready), 32'd1);
        tick();
        idle();
        #1;
        check("t4_lu0_count", 32'(fifo_count), 32'd0);
        check("t4_busy0", busy, 32'h0);
        pipe_wen = 1'b1; pipe_rd = 5'd0;
        #1;
        check("t4_pipe0_wen", 32'(RegWEn), 32'd0);
        tick();
        pipe_wen = 1'b1; pipe_rd = 5'd3; lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
        tick();
        idle();
        pipe_wen = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h5555;
        #1;
        check("t4_q_count", 32'(fifo_count), 32'd1);
        check_write("t4_pipe0_drain", 5'd9, 32'h99);
        tick();
        idle();
        #1;
        check("t4_drained", 32'(fifo_count), 32'd0);

        // 5: head rd 7 pops while rd 7 is re-issued and another result pushes
        lu_issue = 1'b1; lu_issue_rd = 5'd7;
        tick();
        idle();
        pipe_wen = 1'b1; pipe_rd = 5'd2; lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h77;
        tick();
        idle();
        lu_issue = 1'b1; lu_issue_rd = 5'd7;
        lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h88;
        #1;
        check("t5_pre_busy", busy, 32'h0000_0080);
        check_write("t5_pop7", 5'd7, 32'h77);
        tick();
        idle();
        #1;
        check("t5_set_wins", busy, 32'h0000_0080);
        check("t5_count", 32'(fifo_count), 32'd1);
        check_write("t5_pop8", 5'd8, 32'h88);
        tick();
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h777;
        tick();
        idle();
        #1;
        check("t5_clean", busy, 32'h0);

        // 6: asynchronous reset with three entries and busy = 0x700 pending
        for (int k = 0; k < 3; k++) begin
            pipe_wen = 1'b1; pipe_rd = 5'd1;
            lu_issue = 1'b1; lu_issue_rd = 5'(8 + k);
            lu_valid = 1'b1; lu_rd = 5'(8 + k); lu_data = 32'hC000 + 32'(k);
            tick();
        end
        idle();
        #1;
        check("t6_pre_count", 32'(fifo_count), 32'd3);
        check("t6_pre_busy", busy, 32'h0000_0700);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_count", 32'(fifo_count), 32'd0);
        check("t6_rst_busy", busy, 32'h0);
        check("t6_rst_ready", 32'(lu_ready), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check("t6_no_stale", 32'(RegWEn), 32'd0);
            tick();
        end
        check("t6_final_count", 32'(fifo_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-port arbiter and pending-write scoreboard for the register file's single write port. It merges the in-order pipeline writeback with results from a long-latency unit (multiply/divide or load return), which are buffered in a small FIFO. The FIFO drains into idle writeback slots. A 32-bit busy mask tells the hazard logic which destination registers still await a long-latency result. It sits between the WB stage / long-latency unit and the register file write inputs (rsW, dataW_reg, RegWEn).

## Interface
Parameters:
- DEPTH, 4: long-latency result FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pipe_wen  in  1  pipeline WB write request this cycle.
- pipe_rd  in  5  pipeline WB destination.
- pipe_data  in  32  pipeline WB data.
- lu_issue  in  1  long-latency op issued this cycle; marks lu_issue_rd busy.
- lu_issue_rd  in  5  destination of the issued op.
- lu_valid  in  1  long-latency result offered.
- lu_rd  in  5  result destination.
- lu_data  in  32  result data.
- lu_ready  out  1  result accepted when lu_valid && lu_ready.
- rsW  out  5  register file write address.
- dataW_reg  out  32  register file write data.
- RegWEn  out  1  register file write enable.
- busy  out  32  bit i set: register i has an outstanding long-latency write.
- fifo_count  out  $clog2(DEPTH)+1  entries held.

## Operation
- Slot is pipeline-owned when pipe_wen=1 and pipe_rd!=0. The pipeline always wins and is never stalled by this block.
- Slot is free otherwise. Source priority in a free slot:
  - FIFO head, if the FIFO is non-empty; the head is popped.
  - Otherwise a direct write-through of lu_valid && lu_ready, if lu_rd!=0; nothing is enqueued.
  - Otherwise RegWEn=0.
- Enqueue: a handshake is accepted when lu_valid && lu_ready. It is enqueued unless it is consumed by write-through, or lu_rd==0. An lu_rd==0 result is accepted and dropped; it uses no slot and no entry.
- lu_ready = !full. It is not a function of a same-cycle pop. It is 0 while rst=1.
- Push and pop in the same cycle: count unchanged. Ordering is FIFO; results write in acceptance order.
- Write-through is legal only when the FIFO is empty. A non-empty FIFO always drains before any new result.
- Busy mask:
  - set bit lu_issue_rd on lu_issue (ignored for rd 0);
  - clear bit rsW when a long-latency source drives the write (FIFO pop or write-through);
  - pipeline writes never clear busy.
  - Same-register set and clear in one cycle: set wins.
  - busy[0] is always 0.
- Legal-use contract, enforced by decode rather than this block:
  - no issue to an already-busy rd;
  - the pipeline never writes a busy rd.
  - Violations: no checking, behaviour as listed above.
- Outputs rsW/dataW_reg/RegWEn are combinational from the current pipe_* inputs, FIFO head and lu_* inputs. The register file captures them at the following negedge.
- Reset values: FIFO empty, pointers 0, fifo_count 0, busy 0. RegWEn follows inputs: it is 0 unless pipe_wen with a nonzero rd. rsW and dataW_reg carry the selected source, or the pipeline fields when idle.
- Reset mid-operation: FIFO contents and busy bits are discarded immediately (asynchronous). No pending write is ever issued after reset.

## Timing
- Pipeline write: zero added latency; present in the same cycle as pipe_wen.
- Long-latency result:
  - Empty FIFO and free slot: written in the acceptance cycle.
  - Otherwise it waits k free slots, where k is its FIFO position (head = 1).
- busy bit: set visible the cycle after lu_issue; clear visible the cycle after the write cycle.
- fifo_count and lu_ready update on the posedge after the push/pop.
- Full: lu_ready=0 from the cycle after the DEPTH-th push until the posedge after a pop.
- Pointer wrap-around at DEPTH is seamless; no bubble.

## Test plan
- Reset, then lu_issue rd=5, then lu_valid rd=5 data 0xDEADBEEF with pipe idle -> same-cycle RegWEn=1, rsW=5, dataW_reg=0xDEADBEEF; busy[5] is 1 for exactly the cycles between issue and write, then 0.
- pipe_wen=1 continuously (rd=1..4) while 3 lu results (rd 10,11,12) arrive -> count reaches 3, no lu write. When pipe_wen drops: writes to 10,11,12 in three consecutive cycles, count back to 0.
- Fill DEPTH=4 under continuous pipe writes -> lu_ready=0 after the 4th push; the 5th result is held by the producer. One free slot -> pop rd of the 1st entry, lu_ready=1 next cycle, the 5th is accepted. 10 more push/pop cycles exercise pointer wrap with order preserved.
- lu result with rd=0, and pipe_wen=1 with pipe_rd=0 -> RegWEn=0, count unchanged, busy[0] stays 0. In the pipe rd=0 cycle a queued head drains.
- Same cycle: FIFO head (rd=7) pops while lu_issue rd=7 and a new lu result pushes -> busy[7]=1 next cycle (set wins), count unchanged.
- Assert rst with 3 entries queued and busy=0x00000700 -> immediately count=0, busy=0. After release, no stale write appears across 10 idle cycles.
